dmux_stream: RTL and testbench
==============================

Name: dmux_stream

Overview:
- Parametrised 1-to-NOUT registered stream demultiplexer with valid/ready handshake on the input side and on each output channel.
- Each output channel has a one-entry holding register. A word is routed to the channel chosen by sel, or copied to all channels in broadcast mode.
- Out-of-range selects are consumed and counted rather than stalling the stream.
- Successor to the combinational 1:2 dmux, for use wherever one producer feeds several independent consumers.

Parameters:
- WIDTH, 8, data width in bits.
- NOUT, 4, number of output channels (2..16).
- SELW, 2, width of sel; must satisfy 2**SELW >= NOUT.
- CNTW, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  input data word.
- sel  input  SELW  destination channel index.
- bcast  input  1  1 = deliver the word to all NOUT channels.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept this cycle (combinational).
- y  output  NOUT*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
- y_valid  output  NOUT  channel k holds a word.
- y_ready  input  NOUT  consumer k takes its word this cycle.
- err_cnt  output  CNTW  count of dropped out-of-range words.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-transfer):
  - y_valid = 0, y = 0, err_cnt = 0.
  - Any word pending in a holding register is discarded.
  - in_ready is forced to 0 while rst_n is low.
- Slot free condition for channel k: free[k] = !y_valid[k] | y_ready[k]. A slot drained this cycle may be refilled in the same cycle, so a full-rate stream is sustained with no bubble.
- in_ready, evaluated combinationally from sel and bcast:
  - bcast = 1: AND of free[k] over all k.
  - bcast = 0 and sel < NOUT: free[sel].
  - bcast = 0 and sel >= NOUT: 1 (the word is always dropped).
- Transfer: a word is accepted when in_valid & in_ready at a rising clk edge.
- Unicast (sel < NOUT):
  - y[sel] <= a and y_valid[sel] <= 1 at the accepting edge.
  - Latency from input to output is 1 cycle.
- Broadcast: every channel loads a and sets y_valid at the same edge. sel is ignored, and err_cnt is not affected.
- Drop (bcast = 0, sel >= NOUT):
  - No channel is written.
  - err_cnt increments by 1 and saturates at 2**CNTW-1, holding there until reset.
- Output handshake:
  - When y_valid[k] & y_ready[k] and no new word targets k, y_valid[k] clears at the next edge.
  - y[k] keeps its last value after being consumed.
  - When y_valid[k] = 0, y_ready[k] is ignored.
- Channels are independent. A stalled channel blocks only unicast words aimed at it and broadcast words; traffic to other channels is unaffected (no head-of-line blocking beyond the single input word).
- While y_valid[k] = 1 and y_ready[k] = 0, y[k] is held stable.
- While in_valid = 0, no state changes except output drains.
- The input side has no internal buffering. The producer holds a, sel and bcast stable while in_valid & !in_ready.

Test Plan:
- Reset mid-stream:
  - Load channels 1 and 3, then pulse rst_n low asynchronously between edges.
  - Required: y_valid = 0000, y = 0, and err_cnt = 0 immediately, without waiting for a clock edge.
- Unicast routing:
  - NOUT=4, WIDTH=8, y_ready = 1111; send a = 0x11, 0x22, 0x33, 0x44 with sel = 0, 1, 2, 3 on consecutive cycles.
  - Required: each value appears on its channel with y_valid high for exactly one cycle, one cycle after acceptance.
  - Required: in_ready stays 1 throughout.
- Backpressure and same-cycle refill:
  - Hold y_ready[2] = 0 and send a = 0xA0 then 0xA1 to sel = 2.
  - Required: in_ready drops to 0 on the second word while y[2] stays 0xA0.
  - Then raise y_ready[2].
  - Required: 0xA1 is loaded on that same edge and y_valid[2] stays 1.
- Broadcast with one stalled channel:
  - y_ready = 1110, channel 0 occupied, bcast = 1, a = 0x5A.
  - Required: in_ready = 0 until channel 0 drains; then all four channels show 0x5A with y_valid = 1111 one cycle later.
- Independence:
  - Channel 1 is stalled and full.
  - Required: unicast words to sel = 0 and sel = 3 are still accepted and delivered every cycle.
- Drop and saturation:
  - NOUT=3, SELW=2, CNTW=2; send 5 words with sel = 3.
  - Required: in_ready = 1 for all five, no y_valid rises, and err_cnt goes 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/dmux_stream.sv
// 1-to-NOUT registered stream demultiplexer with a one-entry holding register per channel.
// Words go to the sel channel or to all channels (bcast); out-of-range selects are dropped and counted.
module dmux_stream #(
    parameter int WIDTH = 8,
    parameter int NOUT  = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        a,
    input  logic [SELW-1:0]         sel,
    input  logic                    bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NOUT*WIDTH-1:0]   y,
    output logic [NOUT-1:0]         y_valid,
    input  logic [NOUT-1:0]         y_ready,
    output logic [CNTW-1:0]         err_cnt
);

    logic [NOUT-1:0][WIDTH-1:0] data_q, data_d;
    logic [NOUT-1:0]            valid_q, valid_d;
    logic [CNTW-1:0]            err_q, err_d;

    logic [NOUT-1:0] hit;
    logic [NOUT-1:0] free;
    logic [NOUT-1:0] load;
    logic            in_range;
    logic            rdy_raw;
    logic            accept;
    logic            drop;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NOUT; k++) begin
            hit[k] = (int'(sel) == k);
        end
        in_range = |hit;
        // A slot being drained this cycle counts as free, so refill needs no bubble.
        free = ~valid_q | y_ready;

        if (bcast) begin
            rdy_raw = &free;
        end else if (in_range) begin
            rdy_raw = |(hit & free);
        end else begin
            rdy_raw = 1'b1;
        end

        in_ready = rst_n & rdy_raw;
        accept   = in_valid & in_ready;
        drop     = accept & ~bcast & ~in_range;

        load = '0;
        for (int k = 0; k < NOUT; k++) begin
            load[k] = accept & (bcast | hit[k]);
        end

        valid_d = load | (valid_q & ~y_ready);

        data_d = data_q;
        for (int k = 0; k < NOUT; k++) begin
            if (load[k]) begin
                data_d[k] = a;
            end
        end

        err_d = err_q;
        if (drop && (err_q != {CNTW{1'b1}})) begin
            err_d = err_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign y       = data_q;
    assign y_valid = valid_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: a 4-channel instance for routing/handshake and a
// 3-channel, 2-bit-counter instance for drop counting and saturation.
module tb_dmux_stream;

    logic clk;
    logic rst_n;

    // instance A: NOUT=4, WIDTH=8, CNTW=8
    logic [7:0]  a_a;
    logic [1:0]  sel_a;
    logic        bcast_a;
    logic        in_valid_a;
    logic        in_ready_a;
    logic [31:0] y_a;
    logic [3:0]  y_valid_a;
    logic [3:0]  y_ready_a;
    logic [7:0]  err_a;

    // instance B: NOUT=3, WIDTH=8, SELW=2, CNTW=2
    logic [7:0]  a_b;
    logic [1:0]  sel_b;
    logic        bcast_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [23:0] y_b;
    logic [2:0]  y_valid_b;
    logic [2:0]  y_ready_b;
    logic [1:0]  err_b;

    int nchk = 0;
    int nerr = 0;

    dmux_stream #(.WIDTH(8), .NOUT(4), .SELW(2), .CNTW(8)) u_a (
        .clk(clk), .rst_n(rst_n), .a(a_a), .sel(sel_a), .bcast(bcast_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .y(y_a),
        .y_valid(y_valid_a), .y_ready(y_ready_a), .err_cnt(err_a)
    );

    dmux_stream #(.WIDTH(8), .NOUT(3), .SELW(2), .CNTW(2)) u_b (
        .clk(clk), .rst_n(rst_n), .a(a_b), .sel(sel_b), .bcast(bcast_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .y(y_b),
        .y_valid(y_valid_b), .y_ready(y_ready_b), .err_cnt(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] uni [4];
        uni[0] = 8'h11; uni[1] = 8'h22; uni[2] = 8'h33; uni[3] = 8'h44;

        rst_n = 1'b0;
        a_a = '0; sel_a = '0; bcast_a = 1'b0; in_valid_a = 1'b1; y_ready_a = 4'hF;
        a_b = '0; sel_b = '0; bcast_b = 1'b0; in_valid_b = 1'b0; y_ready_b = 3'h7;
        #1;
        chk("rst_in_ready_forced", in_ready_a, 0);
        chk("rst_y_valid", y_valid_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_err", err_a, 0);
        in_valid_a = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // unicast routing at full rate
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1'b1;
            a_a        = uni[i];
            sel_a      = 2'(i);
            #1;
            chk($sformatf("uni_in_ready_%0d", i), in_ready_a, 1);
            step();
            chk($sformatf("uni_valid_%0d", i), y_valid_a, 64'(4'b0001 << i));
            chk($sformatf("uni_data_%0d", i), y_a[i*8 +: 8], uni[i]);
        end
        in_valid_a = 1'b0;
        step();
        chk("uni_drained", y_valid_a, 0);
        chk("uni_keep_last", y_a, 32'h44332211);

        // backpressure and same-cycle refill on channel 2
        y_ready_a = 4'b1011;
        in_valid_a = 1'b1; a_a = 8'hA0; sel_a = 2'd2;
        #1;
        chk("bp_first_ready", in_ready_a, 1);
        step();
        chk("bp_first_valid", y_valid_a, 4'b0100);
        a_a = 8'hA1;
        #1;
        chk("bp_second_blocked", in_ready_a, 0);
        step();
        chk("bp_hold_data", y_a[23:16], 8'hA0);
        chk("bp_hold_valid", y_valid_a, 4'b0100);
        y_ready_a = 4'hF;
        #1;
        chk("bp_refill_ready", in_ready_a, 1);
        step();
        chk("bp_refill_data", y_a[23:16], 8'hA1);
        chk("bp_refill_valid", y_valid_a, 4'b0100);
        in_valid_a = 1'b0;
        step();
        chk("bp_drained", y_valid_a, 0);

        // broadcast waiting on stalled channel 0
        y_ready_a = 4'b1110;
        in_valid_a = 1'b1; a_a = 8'h77; sel_a = 2'd0;
        step();
        chk("bc_ch0_full", y_valid_a, 4'b0001);
        bcast_a = 1'b1; a_a = 8'h5A; sel_a = 2'd3;
        #1;
        chk("bc_blocked", in_ready_a, 0);
        step();
        chk("bc_blocked_valid", y_valid_a, 4'b0001);
        chk("bc_blocked_data0", y_a[7:0], 8'h77);
        y_ready_a = 4'hF;
        #1;
        chk("bc_ready", in_ready_a, 1);
        step();
        chk("bc_all_valid", y_valid_a, 4'hF);
        chk("bc_all_data", y_a, 32'h5A5A5A5A);
        in_valid_a = 1'b0; bcast_a = 1'b0;
        step();
        chk("bc_drained", y_valid_a, 0);
        chk("bc_err_untouched", err_a, 0);

        // independence: channel 1 stalled and full
        y_ready_a = 4'b1101;
        in_valid_a = 1'b1; a_a = 8'hB1; sel_a = 2'd1;
        step();
        chk("ind_ch1_full", y_valid_a, 4'b0010);
        a_a = 8'hC0; sel_a = 2'd0;
        #1;
        chk("ind_sel0_ready", in_ready_a, 1);
        step();
        chk("ind_sel0_valid", y_valid_a, 4'b0011);
        chk("ind_sel0_data", y_a[7:0], 8'hC0);
        a_a = 8'hC3; sel_a = 2'd3;
        #1;
        chk("ind_sel3_ready", in_ready_a, 1);
        step();
        chk("ind_sel3_valid", y_valid_a, 4'b1010);
        chk("ind_sel3_data", y_a[31:24], 8'hC3);
        chk("ind_ch1_held", y_a[15:8], 8'hB1);
        a_a = 8'hB2; sel_a = 2'd1;
        #1;
        chk("ind_sel1_blocked", in_ready_a, 0);
        in_valid_a = 1'b0; y_ready_a = 4'hF;
        step();
        chk("ind_drained", y_valid_a, 0);

        // drop and saturation on the 3-channel instance
        in_valid_b = 1'b1; a_b = 8'hEE; sel_b = 2'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("drop_ready_%0d", i), in_ready_b, 1);
            step();
            chk($sformatf("drop_err_%0d", i), err_b, (i < 3) ? i + 1 : 3);
            chk($sformatf("drop_novalid_%0d", i), y_valid_b, 0);
        end
        a_b = 8'h2C; sel_b = 2'd2;
        step();
        chk("b_inrange_valid", y_valid_b, 3'b100);
        chk("b_inrange_data", y_b[23:16], 8'h2C);
        chk("b_err_held", err_b, 3);
        in_valid_b = 1'b0;

        // asynchronous reset mid-stream with channels 1 and 3 loaded
        y_ready_a = 4'b0101;
        in_valid_a = 1'b1; a_a = 8'hD1; sel_a = 2'd1;
        step();
        a_a = 8'hD3; sel_a = 2'd3;
        step();
        in_valid_a = 1'b0;
        #1;
        chk("mid_loaded", y_valid_a, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", y_valid_a, 0);
        chk("mid_rst_y", y_a, 0);
        chk("mid_rst_err", err_a, 0);
        chk("mid_rst_in_ready", in_ready_a, 0);
        chk("mid_rst_b_err", err_b, 0);
        chk("mid_rst_b_valid", y_valid_b, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", y_valid_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
